// File: rtl/sram_rekey_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : address_mapper / sram_rekey_ctrl
// Purpose  : Scrambled-SRAM key rotation. address_mapper XORs a logical
//            address with the folded key. sram_rekey_ctrl owns the key and
//            serves host accesses. On request it takes a fresh TRNG word and
//            migrates the SRAM in place by swapping physical pairs (p, p^d).
// Revision : 1.0 - initial release
// ============================================================================

module address_mapper #(
  parameter int ADDR_WIDTH = 14,
  parameter int TRNG_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [TRNG_WIDTH-1:0] trng_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  localparam int c_slices = TRNG_WIDTH / ADDR_WIDTH;

  // Remainder MSBs beyond the last whole slice take no part in the fold.
  logic unused_trng;
  assign unused_trng = ^trng_i;

  logic [ADDR_WIDTH-1:0] fold_w;

  // XOR together every whole ADDR_WIDTH-bit slice of the key.
  always_comb begin
    fold_w = '0;
    for (int i = 0; i < c_slices; i++) begin
      fold_w = fold_w ^ trng_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign addr_o = addr_i ^ fold_w;

endmodule

module sram_rekey_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int TRNG_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [DATA_WIDTH-1:0] host_wdata_i,
  output logic                  host_ready_o,
  output logic                  host_rvalid_o,
  output logic [DATA_WIDTH-1:0] host_rdata_o,
  input  logic                  rekey_start_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  trng_valid_i,
  input  logic [TRNG_WIDTH-1:0] trng_data_i,
  output logic                  trng_ready_o,
  output logic [TRNG_WIDTH-1:0] key_out_o,
  output logic                  sram_en_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SCAN   = 3'd2,
    S_RD_A   = 3'd3,
    S_RD_B   = 3'd4,
    S_WR_A   = 3'd5,
    S_WR_B   = 3'd6,
    S_COMMIT = 3'd7
  } state_e;

  state_e                state_q;
  logic [TRNG_WIDTH-1:0] key_q;
  logic [TRNG_WIDTH-1:0] new_q;
  logic [ADDR_WIDTH-1:0] d_q;
  logic [ADDR_WIDTH-1:0] p_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic                  rvalid_q;

  logic [ADDR_WIDTH-1:0] host_phys_w;
  logic [ADDR_WIDTH-1:0] key_fold_w;
  logic [ADDR_WIDTH-1:0] delta_w;
  logic [ADDR_WIDTH-1:0] partner_w;

  // Host path mapping under the committed key.
  address_mapper #(.ADDR_WIDTH(ADDR_WIDTH), .TRNG_WIDTH(TRNG_WIDTH)) u_host_map (
    .addr_i (host_addr_i),
    .trng_i (key_q),
    .addr_o (host_phys_w)
  );

  // fold(key_q) on its own, used to form the migration delta.
  address_mapper #(.ADDR_WIDTH(ADDR_WIDTH), .TRNG_WIDTH(TRNG_WIDTH)) u_key_fold (
    .addr_i ('0),
    .trng_i (key_q),
    .addr_o (key_fold_w)
  );

  // d = fold(key_q) ^ fold(trng_data): every physical word moves by XOR with d.
  address_mapper #(.ADDR_WIDTH(ADDR_WIDTH), .TRNG_WIDTH(TRNG_WIDTH)) u_delta (
    .addr_i (key_fold_w),
    .trng_i (trng_data_i),
    .addr_o (delta_w)
  );

  assign partner_w = p_q ^ d_q;

  assign host_ready_o  = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_COMMIT);
  assign trng_ready_o  = (state_q == S_FETCH);
  assign key_out_o     = key_q;
  assign host_rvalid_o = rvalid_q;
  assign host_rdata_o  = sram_rdata_i;

  // SRAM port mux: host pass-through in IDLE, swap engine during the sweep.
  // WR_A writes the partner word straight from the read bus (that is "b").
  always_comb begin
    sram_en_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    unique case (state_q)
      S_IDLE: begin
        sram_en_o    = host_req_i;
        sram_we_o    = host_req_i & host_we_i;
        sram_addr_o  = host_phys_w;
        sram_wdata_o = host_wdata_i;
      end
      S_RD_A: begin
        sram_en_o   = 1'b1;
        sram_addr_o = p_q;
      end
      S_RD_B: begin
        sram_en_o   = 1'b1;
        sram_addr_o = partner_w;
      end
      S_WR_A: begin
        sram_en_o    = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = p_q;
        sram_wdata_o = sram_rdata_i;
      end
      S_WR_B: begin
        sram_en_o    = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = partner_w;
        sram_wdata_o = a_q;
      end
      default: ;
    endcase
  end

  // Control FSM: key fetch, pairwise swap sweep over p, and key commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      key_q    <= '0;
      new_q    <= '0;
      d_q      <= '0;
      p_q      <= '0;
      a_q      <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= (state_q == S_IDLE) && host_req_i && !host_we_i;
      unique case (state_q)
        S_IDLE: begin
          if (rekey_start_i) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (trng_valid_i) begin
            new_q   <= trng_data_i;
            d_q     <= delta_w;
            p_q     <= '0;
            state_q <= (delta_w == '0) ? S_COMMIT : S_SCAN;
          end
        end
        S_SCAN: begin
          // Each pair is visited once, from its lower member.
          if (p_q < partner_w) begin
            state_q <= S_RD_A;
          end else if (p_q == '1) begin
            state_q <= S_COMMIT;
          end else begin
            p_q <= p_q + ADDR_WIDTH'(1);
          end
        end
        S_RD_A: state_q <= S_RD_B;
        S_RD_B: begin
          a_q     <= sram_rdata_i;
          state_q <= S_WR_A;
        end
        S_WR_A: state_q <= S_WR_B;
        S_WR_B: begin
          if (p_q == '1) begin
            state_q <= S_COMMIT;
          end else begin
            p_q     <= p_q + ADDR_WIDTH'(1);
            state_q <= S_SCAN;
          end
        end
        S_COMMIT: begin
          key_q   <= new_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_rekey_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_rekey_ctrl
// Purpose  : Scoreboard bench for sram_rekey_ctrl (AW=4, DW=8, TW=16) with a
//            behavioural 16-word SRAM and a logical-memory reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_rekey_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_req, host_we, host_ready, host_rvalid;
  logic [3:0]  host_addr;
  logic [7:0]  host_wdata, host_rdata;
  logic        rekey_start, busy, done;
  logic        trng_valid, trng_ready;
  logic [15:0] trng_data, key_out;
  logic        sram_en, sram_we;
  logic [3:0]  sram_addr;
  logic [7:0]  sram_wdata, sram_rdata;

  always #5 clk = ~clk;

  sram_rekey_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TRNG_WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .host_req_i    (host_req),
    .host_we_i     (host_we),
    .host_addr_i   (host_addr),
    .host_wdata_i  (host_wdata),
    .host_ready_o  (host_ready),
    .host_rvalid_o (host_rvalid),
    .host_rdata_o  (host_rdata),
    .rekey_start_i (rekey_start),
    .busy_o        (busy),
    .done_o        (done),
    .trng_valid_i  (trng_valid),
    .trng_data_i   (trng_data),
    .trng_ready_o  (trng_ready),
    .key_out_o     (key_out),
    .sram_en_o     (sram_en),
    .sram_we_o     (sram_we),
    .sram_addr_o   (sram_addr),
    .sram_wdata_o  (sram_wdata),
    .sram_rdata_i  (sram_rdata)
  );

  // Behavioural SRAM, one-cycle read latency.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  // Reference model: logical contents and committed key.
  logic [7:0]  ref_mem [16];
  logic [15:0] ref_key;

  typedef struct { logic [7:0] data; int cyc; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic logic [3:0] fold(input logic [15:0] k);
    return k[3:0] ^ k[7:4] ^ k[11:8] ^ k[15:12];
  endfunction

  // Monitor: every read response is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) done_total++;
    if (!rst && host_rvalid) begin
      if (exp_q.size() == 0) begin
        check("rvalid_spurious", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rdata", host_rdata, e.data);
        check("rvalid_latency", cyc, e.cyc);
      end
    end
  end

  task automatic host_write(input logic [3:0] a, input logic [7:0] v);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = v;
    @(negedge clk);
    check("wr_addr", sram_addr, a ^ fold(ref_key));
    check("wr_strobe", {host_ready, sram_en, sram_we, sram_wdata}, {3'b111, v});
    ref_mem[a] = v;
    @(posedge clk); #1;
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] a);
    exp_t e;
    host_req = 1'b1; host_we = 1'b0; host_addr = a;
    @(negedge clk);
    check("rd_addr", sram_addr, a ^ fold(ref_key));
    check("rd_strobe", {host_ready, sram_en, sram_we}, 3'b110);
    e.data = ref_mem[a]; e.cyc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    host_req = 1'b0;
  endtask

  task automatic fill();
    for (int i = 0; i < 16; i++) host_write(4'(i), 8'(i));
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) host_read(4'(i));
  endtask

  // Physical word L^fold(key) must hold logical word L.
  task automatic check_phys();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] l;
      l = 4'(i);
      check("phys_content", mem[l ^ fold(ref_key)], ref_mem[l]);
    end
  endtask

  task automatic rekey(input logic [15:0] trng, input int hold, input bit with_read,
                       input logic [3:0] raddr, input bit second_start);
    logic [3:0] d;
    int hs_cyc, en_cnt, wr_cnt, done_exp;
    bit seen;
    exp_t e;
    d = fold(ref_key) ^ fold(trng);
    done_exp = done_total + 1;
    en_cnt = 0; wr_cnt = 0; seen = 1'b0;
    rekey_start = 1'b1;
    if (with_read) begin host_req = 1'b1; host_we = 1'b0; host_addr = raddr; end
    @(negedge clk);
    if (with_read) begin
      check("conc_old_map", sram_addr, raddr ^ fold(ref_key));
      e.data = ref_mem[raddr]; e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    rekey_start = 1'b0;
    // A host read held during the whole rotation must never be accepted.
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'($urandom_range(0, 15));
    repeat (hold) @(posedge clk);
    #1;
    @(negedge clk);
    check("fetch_flags", {busy, trng_ready, host_ready, sram_en, done}, 5'b11000);
    trng_valid = 1'b1; trng_data = trng;
    hs_cyc = cyc;
    @(posedge clk); #1;
    trng_valid = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (second_start) rekey_start = (i == 10);
      if (done) begin
        seen = 1'b1;
        host_req = 1'b0;
        check("done_latency", cyc - hs_cyc, (d == 4'd0) ? 1 : 1 + 3 * 16);
      end else begin
        if (sram_en) en_cnt++;
        if (sram_en && sram_we) wr_cnt++;
      end
    end
    rekey_start = 1'b0; host_req = 1'b0;
    if (!seen) check("rekey_timeout", 0, 1);
    check("sweep_accesses", en_cnt, (d == 4'd0) ? 0 : 32);
    check("sweep_writes", wr_cnt, (d == 4'd0) ? 0 : 16);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_commit_flags", {busy, host_ready, done, trng_ready}, 4'b0100);
    check("key_out", key_out, trng);
    ref_key = trng;
    repeat (2) @(posedge clk);
    #1;
    check("done_count", done_total, done_exp);
  endtask

  task automatic reset_mid_sweep();
    bit hit;
    int en_cnt;
    hit = 1'b0; en_cnt = 0;
    rekey_start = 1'b1;
    @(posedge clk); #1;
    rekey_start = 1'b0;
    trng_valid = 1'b1; trng_data = ref_key ^ 16'h0003;
    @(posedge clk); #1;
    trng_valid = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (busy && sram_en && sram_we) hit = 1'b1;
    end
    check("wr_a_reached", hit, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_sweep_flags", {busy, done, host_rvalid, trng_ready, host_ready}, 5'b00001);
    check("rst_sweep_key", key_out, 16'h0000);
    repeat (4) begin
      @(negedge clk);
      if (sram_en) en_cnt++;
    end
    check("rst_sweep_no_access", en_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_flags", {host_ready, busy}, 2'b10);
    ref_key = 16'h0000;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0]  a;
    logic [7:0]  wd;
    logic [15:0] t;
    rst = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    rekey_start = 1'b0; trng_valid = 1'b0; trng_data = '0;
    ref_key = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", {busy, done, host_rvalid, trng_ready, host_ready, sram_en, sram_we}, 7'b0000100);
    check("reset_key", key_out, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic host access under key 0.
    host_write(4'd3, 8'hA5);
    host_read(4'd3);

    // Rotation with d == 0, then with d == 1.
    fill();
    rekey(16'h1111, 0, 1'b0, 4'd0, 1'b0);
    check_phys();
    read_all();
    rekey(16'h0001, 0, 1'b0, 4'd0, 1'b0);
    check_phys();
    read_all();

    // Concurrent read with start, long TRNG stall, ignored second start.
    rekey(ref_key ^ 16'h0050, 10, 1'b1, 4'd5, 1'b1);
    check_phys();

    // Randomised traffic and rotations.
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 8; k++) begin
        a = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) begin
          wd = 8'($urandom);
          host_write(a, wd);
        end else begin
          host_read(a);
        end
      end
      t = 16'($urandom);
      if (it % 3 == 2) t[3:0] = fold(ref_key) ^ t[7:4] ^ t[11:8] ^ t[15:12];
      rekey(t, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      check_phys();
    end
    read_all();

    // Asynchronous reset mid-cycle with a non-zero key.
    if (key_out == 16'h0000) rekey(16'h0001, 0, 1'b0, 4'd0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_async_flags", {busy, done, host_rvalid, trng_ready, host_ready, sram_en, sram_we}, 7'b0000100);
    check("rst_async_key", key_out, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    ref_key = 16'h0000;
    fill();
    read_all();

    // Reset in the middle of the sweep.
    reset_mid_sweep();
    fill();
    read_all();

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_rekey_ctrl.md
# sram_rekey_ctrl

Key-rotation controller for the scrambled SRAM. It owns the current TRNG scrambling key and drives an `address_mapper` instance on the host access path. On request it fetches a fresh TRNG word and migrates the SRAM contents in place, so that every logical address keeps its data under the new mapping. Host accesses are stalled during migration.

## Interface

**Parameters**
- `ADDR_WIDTH`, 14, SRAM address width.
- `DATA_WIDTH`, 32, SRAM word width.
- `TRNG_WIDTH`, 64, key width; `TRNG_WIDTH >= ADDR_WIDTH`.

**Ports**
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `host_req`  in  1  host access request.
- `host_we`  in  1  1 = write, 0 = read.
- `host_addr`  in  `ADDR_WIDTH`  logical address.
- `host_wdata`  in  `DATA_WIDTH`  write data.
- `host_ready`  out  1  a request is accepted when `host_req && host_ready`.
- `host_rvalid`  out  1  read data valid.
- `host_rdata`  out  `DATA_WIDTH`  read data.
- `rekey_start`  in  1  pulse that requests a key rotation.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when the new key is committed.
- `trng_valid`  in  1  TRNG word available.
- `trng_data`  in  `TRNG_WIDTH`  TRNG word.
- `trng_ready`  out  1  high only in FETCH.
- `key_out`  out  `TRNG_WIDTH`  current committed key.
- `sram_en`  out  1  SRAM access strobe.
- `sram_we`  out  1  SRAM write enable.
- `sram_addr`  out  `ADDR_WIDTH`  physical address.
- `sram_wdata`  out  `DATA_WIDTH`  SRAM write data.
- `sram_rdata`  in  `DATA_WIDTH`  SRAM read data, valid one cycle after a read strobe.

## Operation

**Address mapping**
- `fold(k)` is the XOR of the `TRNG_WIDTH/ADDR_WIDTH` whole `ADDR_WIDTH`-bit slices of `k`. Remainder MSBs are ignored.
- Physical address = logical address ^ `fold(key_q)`. This is computed by `address_mapper` with `trng = key_q`.

**States:** IDLE, FETCH, SCAN, RD_A, RD_B, WR_A, WR_B, COMMIT.

- **IDLE**
  - `host_ready` = 1.
  - The host path is combinational to the SRAM: `sram_en = host_req`, `sram_we = host_we`, `sram_addr = mapped(host_addr)`, `sram_wdata = host_wdata`.
  - On a read, `host_rvalid` = 1 on the next cycle and `host_rdata = sram_rdata`.
  - `rekey_start` moves to FETCH.
- **FETCH**
  - `trng_ready` = 1.
  - On `trng_valid`, latch `new_q = trng_data` and `d = fold(key_q) ^ fold(trng_data)`.
  - If `d == 0`, go to COMMIT. Otherwise go to SCAN with `p = 0`.
- **SCAN**
  - If `p < (p ^ d)`, go to RD_A.
  - Otherwise skip: if `p` is all-ones, go to COMMIT; else `p++` and stay in SCAN.
- **RD_A:** read `p`.
- **RD_B:** read `p ^ d`; capture `a = sram_rdata`.
- **WR_A:** capture `b = sram_rdata`; write `b` to `p`.
- **WR_B:** write `a` to `p ^ d`. Then, if `p` is all-ones, go to COMMIT; else `p++` and go to SCAN.
- **COMMIT:** `key_q <= new_q`, `done` = 1, then go to IDLE.

**Rules**
- In every state other than IDLE: `host_ready` = 0 and host requests are not accepted.
- `rekey_start` is ignored outside IDLE.
- `p` is `ADDR_WIDTH` bits wide; XOR is bitwise; no carries anywhere.
- `host_rvalid` is only ever produced by a host read.
- Reset values:
  - State IDLE; `key_q`, `new_q`, `p`, `a`, `b` = 0.
  - `busy`, `done`, `host_rvalid`, `trng_ready` = 0.
  - `host_ready` = 1.
  - `sram_en`, `sram_we` = 0 while `host_req` = 0.
  - `key_out` = 0.

## Timing
- Host read latency is 1 cycle.
- `host_req` and `rekey_start` in the same IDLE cycle:
  - The host access is served with the old key, and its `host_rvalid` still arrives next cycle.
  - FETCH is entered next cycle.
  - FETCH never drives the SRAM, so the pending read data is undisturbed.
- FETCH waits indefinitely for `trng_valid`.
- Sweep duration from the first SCAN cycle to the COMMIT cycle (exclusive) is exactly `3 * 2^ADDR_WIDTH` cycles when `d != 0`:
  - `2^(ADDR_WIDTH-1)` pairs at 5 cycles each.
  - `2^(ADDR_WIDTH-1)` skips at 1 cycle each.
- With `d == 0` there are no SRAM accesses, and the path is FETCH handshake → COMMIT → IDLE.
- `key_out` changes on the clock edge leaving COMMIT. The first host access using the new key is in the following IDLE cycle.
- `busy` rises the cycle after `rekey_start` is accepted and falls on the cycle after COMMIT.
- `rst` mid-sweep:
  - Immediate return to the reset state; `key_out` = 0.
  - SRAM contents are undefined (partially migrated). Software must reinitialise.

## Test plan
Bench configuration: `ADDR_WIDTH=4`, `TRNG_WIDTH=16`, `DATA_WIDTH=8`, behavioural 16-word SRAM with 1-cycle read.

1. **Reset:** assert `rst` asynchronously mid-cycle → `busy`/`done`/`host_rvalid`/`trng_ready` = 0, `host_ready` = 1, `key_out` = 0x0000 immediately.
2. **Host access, key 0:** write 0xA5 to address 3, then read 3 → `sram_addr` = 3 both times; `host_rvalid` with 0xA5 one cycle after the read.
3. **Rekey with `d = 1`:** fill logical `i` with value `i`; `rekey_start`; `trng_data` = 0x0001 → `done` exactly 48 cycles after the first SCAN cycle; physical `p` holds `p ^ 1`; host reads of logical 0..15 return 0..15; `key_out` = 0x0001.
4. **Rekey with `d = 0`:** `trng_data` = 0x1111 from key 0 (fold = 0) → no `sram_en` during rekey; `done` the cycle after the handshake; `key_out` = 0x1111; data unchanged.
5. **Concurrency:**
   - `rekey_start` with `host_req` read in the same cycle → read served with the old mapping; `rvalid` next cycle.
   - `trng_valid` held low for 10 cycles → FETCH held; `host_ready` = 0.
   - A second `rekey_start` during the sweep → ignored; exactly one `done`.
6. **Reset mid-sweep:** `rst` during WR_A → state IDLE, `key_out` = 0, no further SRAM writes, `host_ready` = 1 after release.
